// File: rtl/ivector_heard_serializer_if.sv
// Handshake bundle between the heard() indication source and the serializer,
// plus the 32-bit word stream toward the host portal.
interface ivector_heard_serializer_if;
  logic        heard__ENA;
  logic [31:0] heard_meth;
  logic [31:0] heard_v;
  logic        heard__RDY;
  logic        out_enq__ENA;
  logic [31:0] out_enq_v;
  logic        out_enq__RDY;

  modport master (
    output heard__ENA, heard_meth, heard_v, out_enq__RDY,
    input  heard__RDY, out_enq__ENA, out_enq_v
  );

  modport slave (
    input  heard__ENA, heard_meth, heard_v, out_enq__RDY,
    output heard__RDY, out_enq__ENA, out_enq_v
  );
endinterface

// File: rtl/ivector_heard_serializer.sv
// Buffers heard(meth, v) indications in a small FIFO and emits each one as a
// header word {meth, len=2} followed by a payload word; bad methods are counted.
module ivector_heard_serializer #(
  parameter int DEPTH    = 4,
  parameter int NUM_METH = 10
) (
  input  logic                         CLK,
  input  logic                         nRST,
  ivector_heard_serializer_if.slave    bus,
  output logic [15:0]                  drop_count
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [15:0] meth;
    logic [31:0] v;
  } ent_t;

  typedef enum logic {HDR, PAY} state_t;

  ent_t          mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          full, empty;
  logic          meth_ok, push, pop, drop;
  state_t        state_q, state_d;
  ent_t          head;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign meth_ok = (bus.heard_meth < 32'(NUM_METH));
  assign push    = bus.heard__ENA && meth_ok && !full;
  assign drop    = bus.heard__ENA && !meth_ok;
  assign head    = mem[rd_ptr[AW-1:0]];

  assign bus.heard__RDY   = !full;
  assign bus.out_enq__ENA = !empty && bus.out_enq__RDY;
  assign pop              = bus.out_enq__ENA && (state_q == PAY);

  always_ff @(posedge CLK) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= '{meth: bus.heard_meth[15:0], v: bus.heard_v};
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      state_q    <= HDR;
      drop_count <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      state_q <= state_d;
      if (drop && drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;
    end
  end

  always_comb begin
    state_d       = state_q;
    bus.out_enq_v = 32'h0;
    if (bus.out_enq__ENA)
      state_d = (state_q == HDR) ? PAY : HDR;
    if (!empty) begin
      case (state_q)
        HDR:     bus.out_enq_v = {head.meth, 16'd2};
        default: bus.out_enq_v = head.v;
      endcase
    end
  end
endmodule

// File: tb/tb_ivector_heard_serializer.sv
// Directed bench for ivector_heard_serializer: each task drives one scenario
// and compares the word stream and flags against hand-computed values.
module tb_ivector_heard_serializer;
  logic        CLK;
  logic        nRST;
  logic [15:0] drop_count;
  int          vec;
  int          errs;

  ivector_heard_serializer_if bus();

  ivector_heard_serializer #(.DEPTH(4), .NUM_METH(10)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .bus        (bus),
    .drop_count (drop_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic test_reset();
    nRST = 1'b0;
    bus.heard__ENA = 1'b0; bus.heard_meth = '0; bus.heard_v = '0;
    bus.out_enq__RDY = 1'b1;
    @(negedge CLK); #1;
    vec++; if (bus.out_enq__ENA !== 1'b0) begin errs++; $display("FAIL rst_ena got %b want 0", bus.out_enq__ENA); end
    vec++; if (bus.out_enq_v !== 32'h0) begin errs++; $display("FAIL rst_v got %h want 0", bus.out_enq_v); end
    vec++; if (bus.heard__RDY !== 1'b1) begin errs++; $display("FAIL rst_rdy got %b want 1", bus.heard__RDY); end
    vec++; if (drop_count !== 16'h0) begin errs++; $display("FAIL rst_drop got %h want 0", drop_count); end
    @(negedge CLK); nRST = 1'b1;
  endtask

  task automatic test_single();
    @(negedge CLK);
    bus.heard__ENA = 1'b1; bus.heard_meth = 32'd3; bus.heard_v = 32'hDEADBEEF;
    #1;
    vec++; if (bus.out_enq__ENA !== 1'b0) begin errs++; $display("FAIL single_pre got %b want 0", bus.out_enq__ENA); end
    @(negedge CLK); bus.heard__ENA = 1'b0; #1;
    vec++; if (bus.out_enq__ENA !== 1'b1 || bus.out_enq_v !== 32'h0003_0002) begin
      errs++; $display("FAIL single_hdr got ena=%b v=%h want 1 00030002", bus.out_enq__ENA, bus.out_enq_v); end
    @(negedge CLK); #1;
    vec++; if (bus.out_enq__ENA !== 1'b1 || bus.out_enq_v !== 32'hDEADBEEF) begin
      errs++; $display("FAIL single_pay got ena=%b v=%h want 1 deadbeef", bus.out_enq__ENA, bus.out_enq_v); end
    @(negedge CLK); #1;
    vec++; if (bus.out_enq__ENA !== 1'b0 || bus.out_enq_v !== 32'h0 || bus.heard__RDY !== 1'b1) begin
      errs++; $display("FAIL single_idle got ena=%b v=%h rdy=%b want 0 0 1", bus.out_enq__ENA, bus.out_enq_v, bus.heard__RDY); end
  endtask

  task automatic test_fill();
    int          nw;
    int          sent_at;
    bit          sent;
    logic [31:0] expw;
    nw = 0; sent = 0; sent_at = -1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      bus.out_enq__RDY = 1'b0;
      vec++; if (bus.heard__RDY !== 1'b1) begin errs++; $display("FAIL fill_rdy%0d got %b want 1", i, bus.heard__RDY); end
      bus.heard__ENA = 1'b1; bus.heard_meth = 32'(i); bus.heard_v = 32'(100 + i);
    end
    @(negedge CLK); bus.heard__ENA = 1'b0; #1;
    vec++; if (bus.heard__RDY !== 1'b0) begin errs++; $display("FAIL fill_full got %b want 0", bus.heard__RDY); end
    vec++; if (bus.out_enq__ENA !== 1'b0 || bus.out_enq_v !== 32'h0000_0002) begin
      errs++; $display("FAIL fill_stalled got ena=%b v=%h want 0 00000002", bus.out_enq__ENA, bus.out_enq_v); end
    repeat (2) begin
      @(negedge CLK); #1;
      vec++; if (bus.heard__RDY !== 1'b0) begin errs++; $display("FAIL fill_hold got %b want 0", bus.heard__RDY); end
    end
    for (int c = 0; c < 40 && nw < 10; c++) begin
      @(negedge CLK);
      bus.out_enq__RDY = 1'b1;
      bus.heard__ENA = 1'b0;
      if (!sent && bus.heard__RDY) begin
        bus.heard__ENA = 1'b1; bus.heard_meth = 32'd4; bus.heard_v = 32'd104;
        sent = 1; sent_at = nw;
      end
      #1;
      if (bus.out_enq__ENA) begin
        expw = nw[0] ? 32'(100 + nw / 2) : {16'(nw / 2), 16'd2};
        vec++; if (bus.out_enq_v !== expw) begin errs++; $display("FAIL fill_word%0d got %h want %h", nw, bus.out_enq_v, expw); end
        if (nw == 1) begin
          vec++; if (bus.heard__RDY !== 1'b0) begin errs++; $display("FAIL fill_rdy_at_pop got %b want 0", bus.heard__RDY); end
        end
        nw++;
      end
    end
    bus.heard__ENA = 1'b0;
    vec++; if (nw !== 10) begin errs++; $display("FAIL fill_count got %0d want 10", nw); end
    vec++; if (sent_at !== 2) begin errs++; $display("FAIL fill_fifth_at got %0d want 2", sent_at); end
    @(negedge CLK); #1;
    vec++; if (bus.out_enq__ENA !== 1'b0) begin errs++; $display("FAIL fill_drained got %b want 0", bus.out_enq__ENA); end
  endtask

  task automatic test_stall();
    @(negedge CLK);
    bus.out_enq__RDY = 1'b1;
    bus.heard__ENA = 1'b1; bus.heard_meth = 32'd7; bus.heard_v = 32'd5;
    @(negedge CLK); bus.heard__ENA = 1'b0; #1;
    vec++; if (bus.out_enq__ENA !== 1'b1 || bus.out_enq_v !== 32'h0007_0002) begin
      errs++; $display("FAIL stall_hdr got ena=%b v=%h want 1 00070002", bus.out_enq__ENA, bus.out_enq_v); end
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); bus.out_enq__RDY = 1'b0; #1;
      vec++; if (bus.out_enq__ENA !== 1'b0 || bus.out_enq_v !== 32'd5) begin
        errs++; $display("FAIL stall_hold%0d got ena=%b v=%h want 0 5", i, bus.out_enq__ENA, bus.out_enq_v); end
    end
    @(negedge CLK); bus.out_enq__RDY = 1'b1; #1;
    vec++; if (bus.out_enq__ENA !== 1'b1 || bus.out_enq_v !== 32'd5) begin
      errs++; $display("FAIL stall_pay got ena=%b v=%h want 1 5", bus.out_enq__ENA, bus.out_enq_v); end
    @(negedge CLK); #1;
    vec++; if (bus.out_enq__ENA !== 1'b0) begin errs++; $display("FAIL stall_idle got %b want 0", bus.out_enq__ENA); end
  endtask

  task automatic test_drop();
    @(negedge CLK);
    bus.out_enq__RDY = 1'b1;
    bus.heard__ENA = 1'b1; bus.heard_meth = 32'd10; bus.heard_v = 32'd1;
    #1;
    vec++; if (bus.out_enq__ENA !== 1'b0) begin errs++; $display("FAIL drop_a got %b want 0", bus.out_enq__ENA); end
    @(negedge CLK); bus.heard_meth = 32'hFFFF_FFFF; #1;
    vec++; if (bus.out_enq__ENA !== 1'b0) begin errs++; $display("FAIL drop_b got %b want 0", bus.out_enq__ENA); end
    @(negedge CLK); bus.heard__ENA = 1'b0; #1;
    vec++; if (drop_count !== 16'd2) begin errs++; $display("FAIL drop_count got %0d want 2", drop_count); end
    vec++; if (bus.out_enq__ENA !== 1'b0 || bus.heard__RDY !== 1'b1) begin
      errs++; $display("FAIL drop_empty got ena=%b rdy=%b want 0 1", bus.out_enq__ENA, bus.heard__RDY); end
    repeat (65533) begin
      @(negedge CLK); bus.heard__ENA = 1'b1; bus.heard_meth = 32'd10;
    end
    @(negedge CLK); bus.heard__ENA = 1'b0; #1;
    vec++; if (drop_count !== 16'hFFFF) begin errs++; $display("FAIL drop_max got %h want ffff", drop_count); end
    @(negedge CLK); bus.heard__ENA = 1'b1; bus.heard_meth = 32'hFFFF_FFFF;
    @(negedge CLK); bus.heard__ENA = 1'b0; #1;
    vec++; if (drop_count !== 16'hFFFF) begin errs++; $display("FAIL drop_sat got %h want ffff", drop_count); end
  endtask

  task automatic test_back_to_back();
    int          nw;
    int          np;
    logic [31:0] expw;
    nw = 0; np = 2;
    @(negedge CLK);
    bus.out_enq__RDY = 1'b0;
    bus.heard__ENA = 1'b1; bus.heard_meth = 32'd0; bus.heard_v = 32'd1000;
    @(negedge CLK);
    bus.heard_meth = 32'd1; bus.heard_v = 32'd1001;
    for (int c = 0; c < 200 && nw < 40; c++) begin
      @(negedge CLK);
      bus.heard__ENA = 1'b0;
      bus.out_enq__RDY = 1'b1;
      #1;
      if (bus.out_enq__ENA) begin
        expw = nw[0] ? 32'(1000 + nw / 2) : {16'((nw / 2) % 10), 16'd2};
        vec++; if (bus.out_enq_v !== expw) begin errs++; $display("FAIL b2b_word%0d got %h want %h", nw, bus.out_enq_v, expw); end
        // Refill on the pop cycle so push and pop coincide at occupancy 2.
        if (nw[0] && np < 20) begin
          vec++; if (bus.heard__RDY !== 1'b1) begin errs++; $display("FAIL b2b_rdy%0d got %b want 1", np, bus.heard__RDY); end
          bus.heard__ENA = 1'b1; bus.heard_meth = 32'(np % 10); bus.heard_v = 32'(1000 + np);
          np++;
        end
        nw++;
      end
    end
    vec++; if (nw !== 40 || np !== 20) begin errs++; $display("FAIL b2b_count got words=%0d pushes=%0d want 40 20", nw, np); end
    @(negedge CLK); bus.heard__ENA = 1'b0; #1;
    vec++; if (bus.out_enq__ENA !== 1'b0) begin errs++; $display("FAIL b2b_drained got %b want 0", bus.out_enq__ENA); end
  endtask

  task automatic test_async_reset();
    @(negedge CLK);
    bus.out_enq__RDY = 1'b1;
    bus.heard__ENA = 1'b1; bus.heard_meth = 32'd2; bus.heard_v = 32'd77;
    @(negedge CLK); bus.heard__ENA = 1'b0; #1;
    vec++; if (bus.out_enq__ENA !== 1'b1 || bus.out_enq_v !== 32'h0002_0002) begin
      errs++; $display("FAIL arst_hdr got ena=%b v=%h want 1 00020002", bus.out_enq__ENA, bus.out_enq_v); end
    @(posedge CLK); #2 nRST = 1'b0; #1;
    vec++; if (bus.out_enq__ENA !== 1'b0 || bus.out_enq_v !== 32'h0) begin
      errs++; $display("FAIL arst_now got ena=%b v=%h want 0 0", bus.out_enq__ENA, bus.out_enq_v); end
    vec++; if (bus.heard__RDY !== 1'b1 || drop_count !== 16'h0) begin
      errs++; $display("FAIL arst_state got rdy=%b drop=%h want 1 0", bus.heard__RDY, drop_count); end
    @(negedge CLK); @(negedge CLK); nRST = 1'b1; #1;
    vec++; if (bus.out_enq__ENA !== 1'b0) begin errs++; $display("FAIL arst_stale got %b want 0", bus.out_enq__ENA); end
    @(negedge CLK);
    bus.heard__ENA = 1'b1; bus.heard_meth = 32'd1; bus.heard_v = 32'd9;
    #1;
    vec++; if (bus.out_enq__ENA !== 1'b0) begin errs++; $display("FAIL arst_pre got %b want 0", bus.out_enq__ENA); end
    @(negedge CLK); bus.heard__ENA = 1'b0; #1;
    vec++; if (bus.out_enq__ENA !== 1'b1 || bus.out_enq_v !== 32'h0001_0002) begin
      errs++; $display("FAIL arst_hdr2 got ena=%b v=%h want 1 00010002", bus.out_enq__ENA, bus.out_enq_v); end
    @(negedge CLK); #1;
    vec++; if (bus.out_enq__ENA !== 1'b1 || bus.out_enq_v !== 32'd9) begin
      errs++; $display("FAIL arst_pay2 got ena=%b v=%h want 1 9", bus.out_enq__ENA, bus.out_enq_v); end
    @(negedge CLK); #1;
    vec++; if (bus.out_enq__ENA !== 1'b0) begin errs++; $display("FAIL arst_idle got %b want 0", bus.out_enq__ENA); end
  endtask

  initial begin
    vec = 0;
    errs = 0;
    test_reset();
    test_single();
    test_fill();
    test_stall();
    test_drop();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
